mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Parameters
REQ-001 size, default 2, matrix dimension (cells per row/column).
REQ-002 cell_width, default 32, bits per matrix cell.
REQ-003 address_width, default $clog2(size*size), register-file cell address width.
REQ-004 width, default size*cell_width, data bus width (one row/column).

Interface
REQ-005 in_clk  in  1  single clock; all state changes on its rising edge.
REQ-006 in_reset  in  1  asynchronous, active-high reset.
REQ-007 in_cp_read_en  in  1  coprocessor read request, held until out_cp_ready.
REQ-008 in_cp_write_en  in  1  coprocessor write request, held until out_cp_ready.
REQ-009 in_cp_address  in  address_width  requested cell address.
REQ-010 in_cp_type  in  2  access type: 00 cell, 01 row, 10 column, 11 reserved.
REQ-011 in_cp_matrix  in  2  matrix select: A=00, B=01, C=10, 11 invalid.
REQ-012 in_cp_data  in  width  write data.
REQ-013 out_cp_data  out  width  read data returned to coprocessor.
REQ-014 out_cp_ready  out  1  one-cycle completion pulse (feeds coprocessor in_data_ready).
REQ-015 out_rf_address/out_rf_type/out_rf_matrix  out  address_width/2/2  register-file request fields.
REQ-016 out_rf_data  out  width  register-file write data.
REQ-017 out_rf_read_en, out_rf_write_en  out  1 each  register-file strobes.
REQ-018 in_rf_data  in  width  register-file read data, valid the cycle after read_en is sampled.
REQ-019 out_busy  out  1  high in every state except IDLE.
REQ-020 out_err  out  1  sticky protocol-error flag.
REQ-021 out_rd_count, out_wr_count  out  16 each  completed-transaction counters.

Function
REQ-022 States: IDLE, RD_ISSUE, RD_CAPT, WR_ISSUE, DONE; all outputs registered.
REQ-023 Requests sampled only in IDLE; request fields latched on the sampling edge.
REQ-024 IDLE + read_en (edge E0): out_rf_* loaded, out_rf_read_en<=1, -> RD_ISSUE.
REQ-025 RD_ISSUE (E1): out_rf_read_en<=0, -> RD_CAPT.
REQ-026 RD_CAPT (E2): out_cp_data<=in_rf_data, out_cp_ready<=1, out_rd_count+1, -> DONE.
REQ-027 IDLE + write_en only (E0): out_rf_* and out_rf_data loaded, out_rf_write_en<=1, -> WR_ISSUE.
REQ-028 WR_ISSUE (E1): out_rf_write_en<=0, out_cp_ready<=1, out_wr_count+1, -> DONE.
REQ-029 DONE (next edge): out_cp_ready<=0, -> IDLE; requests still high during DONE are ignored.
REQ-030 Read latency: ready high in the cycle after E2; write latency: ready high in the cycle after E1.
REQ-031 Each strobe (out_rf_read_en/out_rf_write_en) is high for exactly one cycle per transaction; never both high.
REQ-032 read_en and write_en both high in IDLE: read serviced, write dropped, out_err<=1.
REQ-033 in_cp_matrix=11 or in_cp_type=11 in IDLE: no rf strobe, out_err<=1, out_cp_data<=0, out_cp_ready<=1, -> DONE; counters unchanged.
REQ-034 out_cp_data holds its value until the next completed read or reset.
REQ-035 Counters saturate at 16'hFFFF (no wrap).
REQ-036 out_err cleared only by reset.

Reset
REQ-037 in_reset high: state=IDLE immediately; all outputs (data, strobes, ready, busy, err, counters) 0 without waiting for a clock edge.
REQ-038 Reset mid-transaction aborts it; no ready pulse follows; strobes drop asynchronously.

Verification
REQ-039 Read A row 2 (matrix 00, type 01, addr 2), rf returns 64'h0000_0003_0000_0004 -> read_en pulse 1 cycle, ready 3 edges after sampling, out_cp_data matches, rd_count=1.
REQ-040 Write C cell addr 3 data 64'h0000_0000_DEAD_BEEF -> write_en one cycle with fields matching, ready in following cycle, wr_count=1, err=0.
REQ-041 Read and write asserted together -> only read_en strobes, err=1, rd_count=1, wr_count=0.
REQ-042 matrix=11 read -> no rf strobe, ready pulse, out_cp_data=0, err=1, counters 0.
REQ-043 Reset asserted during RD_ISSUE -> all outputs 0 asynchronously, no ready pulse afterward; fresh read then completes normally.
REQ-044 Request held high through DONE -> exactly one transaction per request; back-to-back requests each complete, counters increment once each.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Coprocessor-to-register-file access controller: turns held cp read/write requests
// into single-cycle register-file strobes and returns a one-cycle completion pulse.
module mem_access_ctrl #(
  parameter int unsigned size          = 2,
  parameter int unsigned cell_width    = 32,
  parameter int unsigned address_width = $clog2(size * size),
  parameter int unsigned width         = size * cell_width
) (
  input  logic                     in_clk,
  input  logic                     in_reset,
  input  logic                     in_cp_read_en,
  input  logic                     in_cp_write_en,
  input  logic [address_width-1:0] in_cp_address,
  input  logic [1:0]               in_cp_type,
  input  logic [1:0]               in_cp_matrix,
  input  logic [width-1:0]         in_cp_data,
  output logic [width-1:0]         out_cp_data,
  output logic                     out_cp_ready,
  output logic [address_width-1:0] out_rf_address,
  output logic [1:0]               out_rf_type,
  output logic [1:0]               out_rf_matrix,
  output logic [width-1:0]         out_rf_data,
  output logic                     out_rf_read_en,
  output logic                     out_rf_write_en,
  input  logic [width-1:0]         in_rf_data,
  output logic                     out_busy,
  output logic                     out_err,
  output logic [15:0]              out_rd_count,
  output logic [15:0]              out_wr_count
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPT,
    WR_ISSUE,
    DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [width-1:0]         cp_data_q, cp_data_d;
  logic                     cp_ready_q, cp_ready_d;
  logic [address_width-1:0] rf_addr_q, rf_addr_d;
  logic [1:0]               rf_type_q, rf_type_d;
  logic [1:0]               rf_matrix_q, rf_matrix_d;
  logic [width-1:0]         rf_data_q, rf_data_d;
  logic                     rf_rd_q, rf_rd_d;
  logic                     rf_wr_q, rf_wr_d;
  logic                     busy_q, busy_d;
  logic                     err_q, err_d;
  logic [15:0]              rd_cnt_q, rd_cnt_d;
  logic [15:0]              wr_cnt_q, wr_cnt_d;

  logic req_invalid;
  assign req_invalid = (in_cp_matrix == 2'b11) || (in_cp_type == 2'b11);

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      state_q     <= IDLE;
      cp_data_q   <= '0;
      cp_ready_q  <= 1'b0;
      rf_addr_q   <= '0;
      rf_type_q   <= '0;
      rf_matrix_q <= '0;
      rf_data_q   <= '0;
      rf_rd_q     <= 1'b0;
      rf_wr_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      cp_data_q   <= cp_data_d;
      cp_ready_q  <= cp_ready_d;
      rf_addr_q   <= rf_addr_d;
      rf_type_q   <= rf_type_d;
      rf_matrix_q <= rf_matrix_d;
      rf_data_q   <= rf_data_d;
      rf_rd_q     <= rf_rd_d;
      rf_wr_q     <= rf_wr_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cp_data_d   = cp_data_q;
    cp_ready_d  = cp_ready_q;
    rf_addr_d   = rf_addr_q;
    rf_type_d   = rf_type_q;
    rf_matrix_d = rf_matrix_q;
    rf_data_d   = rf_data_q;
    rf_rd_d     = rf_rd_q;
    rf_wr_d     = rf_wr_q;
    err_d       = err_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (in_cp_read_en || in_cp_write_en) begin
          if (req_invalid) begin
            // Rejected request still completes so the coprocessor never stalls.
            err_d      = 1'b1;
            cp_data_d  = '0;
            cp_ready_d = 1'b1;
            state_d    = DONE;
          end else begin
            rf_addr_d   = in_cp_address;
            rf_type_d   = in_cp_type;
            rf_matrix_d = in_cp_matrix;
            if (in_cp_read_en) begin
              rf_rd_d = 1'b1;
              state_d = RD_ISSUE;
              if (in_cp_write_en) err_d = 1'b1;
            end else begin
              rf_data_d = in_cp_data;
              rf_wr_d   = 1'b1;
              state_d   = WR_ISSUE;
            end
          end
        end
      end
      RD_ISSUE: begin
        rf_rd_d = 1'b0;
        state_d = RD_CAPT;
      end
      RD_CAPT: begin
        cp_data_d  = in_rf_data;
        cp_ready_d = 1'b1;
        if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
        state_d    = DONE;
      end
      WR_ISSUE: begin
        rf_wr_d    = 1'b0;
        cp_ready_d = 1'b1;
        if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
        state_d    = DONE;
      end
      DONE: begin
        cp_ready_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign out_cp_data     = cp_data_q;
  assign out_cp_ready    = cp_ready_q;
  assign out_rf_address  = rf_addr_q;
  assign out_rf_type     = rf_type_q;
  assign out_rf_matrix   = rf_matrix_q;
  assign out_rf_data     = rf_data_q;
  assign out_rf_read_en  = rf_rd_q;
  assign out_rf_write_en = rf_wr_q;
  assign out_busy        = busy_q;
  assign out_err         = err_q;
  assign out_rd_count    = rd_cnt_q;
  assign out_wr_count    = wr_cnt_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a transaction-level reference model;
// the bench also plays the register file, presenting read data only in the valid cycle.
module tb_mem_access_ctrl;

  localparam int unsigned AW = 2;
  localparam int unsigned W  = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          cp_rd, cp_wr;
  logic [AW-1:0] cp_addr;
  logic [1:0]    cp_type, cp_mat;
  logic [W-1:0]  cp_wdata;
  logic [W-1:0]  cp_rdata;
  logic          cp_ready;
  logic [AW-1:0] rf_addr;
  logic [1:0]    rf_type, rf_mat;
  logic [W-1:0]  rf_wdata;
  logic          rf_rd, rf_wr;
  logic [W-1:0]  rf_rdata;
  logic          busy, err;
  logic [15:0]   rd_count, wr_count;

  int unsigned n_checks = 0;
  int unsigned n_errs   = 0;

  // Reference model state: what the coprocessor should be able to observe.
  bit          m_err;
  int unsigned m_rd_cnt, m_wr_cnt;
  logic [W-1:0] m_cp_data;

  mem_access_ctrl #(.size(2), .cell_width(32)) dut (
    .in_clk(clk), .in_reset(rst),
    .in_cp_read_en(cp_rd), .in_cp_write_en(cp_wr),
    .in_cp_address(cp_addr), .in_cp_type(cp_type), .in_cp_matrix(cp_mat),
    .in_cp_data(cp_wdata), .out_cp_data(cp_rdata), .out_cp_ready(cp_ready),
    .out_rf_address(rf_addr), .out_rf_type(rf_type), .out_rf_matrix(rf_mat),
    .out_rf_data(rf_wdata), .out_rf_read_en(rf_rd), .out_rf_write_en(rf_wr),
    .in_rf_data(rf_rdata), .out_busy(busy), .out_err(err),
    .out_rd_count(rd_count), .out_wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_err = 0; m_rd_cnt = 0; m_wr_cnt = 0; m_cp_data = '0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_err"}, err, m_err);
    chk({tag, "_rdcnt"}, rd_count, m_rd_cnt);
    chk({tag, "_wrcnt"}, wr_count, m_wr_cnt);
    chk({tag, "_cpdata"}, cp_rdata, m_cp_data);
  endtask

  // One coprocessor request. Sample index s counts negedges after the sampling edge E0.
  task automatic run_txn(input bit rd, input bit wr, input logic [AW-1:0] addr,
                         input logic [1:0] typ, input logic [1:0] mat,
                         input logic [W-1:0] wdata, input logic [W-1:0] rfval, input bit hold);
    bit inval, exp_rd, exp_wr, prev_rd, dropped, both;
    int exp_lat, rdy_at, rdy_hits, rd_hits, wr_hits, rd_s, wr_s, drop_at;
    inval   = (mat == 2'b11) || (typ == 2'b11);
    exp_rd  = rd && !inval;
    exp_wr  = wr && !rd && !inval;
    exp_lat = inval ? 1 : (rd ? 3 : 2);
    prev_rd = 0; dropped = 0; both = 0;
    rdy_at = -1; rdy_hits = 0; rd_hits = 0; wr_hits = 0; rd_s = -1; wr_s = -1; drop_at = -1;

    @(negedge clk);
    cp_rd = rd; cp_wr = wr; cp_addr = addr; cp_type = typ; cp_mat = mat; cp_wdata = wdata;
    for (int s = 1; s <= 7; s++) begin
      @(posedge clk);
      @(negedge clk);
      rf_rdata = prev_rd ? rfval : {$urandom, $urandom};
      prev_rd  = rf_rd;
      if (s == 1) chk("busy_active", busy, 1'b1);
      if (rf_rd && rf_wr) both = 1;
      if (rf_rd) begin
        rd_hits++;
        if (rd_s < 0) rd_s = s;
        chk("rd_addr", rf_addr, addr);
        chk("rd_type", rf_type, typ);
        chk("rd_mat", rf_mat, mat);
      end
      if (rf_wr) begin
        wr_hits++;
        if (wr_s < 0) wr_s = s;
        chk("wr_addr", rf_addr, addr);
        chk("wr_type", rf_type, typ);
        chk("wr_mat", rf_mat, mat);
        chk("wr_data", rf_wdata, wdata);
      end
      if (cp_ready) begin
        rdy_hits++;
        if (rdy_at < 0) begin
          rdy_at  = s;
          drop_at = hold ? s + 1 : s;
        end
      end
      if (!dropped && s == drop_at) begin
        cp_rd = 0; cp_wr = 0; dropped = 1;
      end
    end
    if (!dropped) begin
      cp_rd = 0; cp_wr = 0;
    end

    if (exp_rd) m_cp_data = rfval;
    else if (inval) m_cp_data = '0;
    if (inval || (rd && wr)) m_err = 1;
    if (exp_rd && m_rd_cnt < 65535) m_rd_cnt++;
    if (exp_wr && m_wr_cnt < 65535) m_wr_cnt++;

    chk("strobes_exclusive", both, 1'b0);
    chk("rd_strobe_cycles", rd_hits, exp_rd);
    chk("wr_strobe_cycles", wr_hits, exp_wr);
    if (exp_rd) chk("rd_strobe_at", rd_s, 1);
    if (exp_wr) chk("wr_strobe_at", wr_s, 1);
    chk("ready_pulses", rdy_hits, 1);
    chk("ready_latency", rdy_at, exp_lat);
    chk("busy_idle", busy, 1'b0);
    check_state("txn");
  endtask

  task automatic reset_during_read();
    int bad;
    bad = 0;
    @(negedge clk);
    cp_rd = 1; cp_wr = 0; cp_addr = 2'd1; cp_type = 2'b00; cp_mat = 2'b01;
    @(posedge clk);
    @(negedge clk);
    chk("rst_pre_strobe", rf_rd, 1'b1);
    #1 rst = 1;
    #1;
    model_reset();
    chk("rst_async_rd", rf_rd, 1'b0);
    chk("rst_async_busy", busy, 1'b0);
    chk("rst_async_ready", cp_ready, 1'b0);
    check_state("rst_async");
    cp_rd = 0;
    @(negedge clk);
    rst = 0;
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      if (cp_ready || rf_rd || rf_wr || busy) bad++;
    end
    chk("rst_no_resume", bad, 0);
  endtask

  initial begin
    rst = 1; cp_rd = 0; cp_wr = 0; cp_addr = '0; cp_type = '0; cp_mat = '0;
    cp_wdata = '0; rf_rdata = '0;
    model_reset();
    #2;
    chk("reset_busy", busy, 1'b0);
    chk("reset_ready", cp_ready, 1'b0);
    chk("reset_strobes", {rf_rd, rf_wr}, 2'b00);
    check_state("reset");
    @(negedge clk);
    rst = 0;

    run_txn(1, 0, 2'd2, 2'b01, 2'b00, '0, 64'h0000_0003_0000_0004, 0);
    run_txn(0, 1, 2'd3, 2'b00, 2'b10, 64'h0000_0000_DEAD_BEEF, '0, 0);
    run_txn(1, 1, 2'd1, 2'b10, 2'b01, 64'h1234_5678_9ABC_DEF0, 64'hCAFE_F00D_0BAD_BEEF, 0);
    run_txn(1, 0, 2'd0, 2'b00, 2'b11, '0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_txn(0, 1, 2'd0, 2'b11, 2'b00, 64'h55, '0, 0);

    reset_during_read();
    run_txn(1, 0, 2'd3, 2'b00, 2'b00, '0, 64'h0123_4567_89AB_CDEF, 0);

    run_txn(1, 0, 2'd1, 2'b01, 2'b01, '0, 64'hA5A5_A5A5_5A5A_5A5A, 1);
    run_txn(0, 1, 2'd2, 2'b10, 2'b10, 64'h0F0F_0F0F_F0F0_F0F0, '0, 1);
    run_txn(0, 1, 2'd2, 2'b00, 2'b00, 64'h1111_2222_3333_4444, '0, 1);

    for (int i = 0; i < 150; i++) begin
      bit rd, wr;
      logic [1:0] mat, typ;
      rd  = 1'($urandom);
      wr  = 1'($urandom);
      if (!rd && !wr) rd = 1;
      mat = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      typ = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      run_txn(rd, wr, 2'($urandom), typ, mat, {$urandom, $urandom}, {$urandom, $urandom},
              1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
